id_regfile_scoreboard: RTL and testbench

//  ID-stage end of the writeback interface: consumes RegWrite_ID/write_reg_ID/write_data_ID from the WB stage.

---
 rtl/id_regfile_scoreboard_pkg.sv | 18 +
 rtl/id_regfile_scoreboard_if.sv | 40 ++++
 rtl/id_regfile_scoreboard_regfile_2r1w.sv | 49 ++++
 rtl/id_regfile_scoreboard.sv | 113 +++++++++++
 tb/tb_id_regfile_scoreboard.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/id_regfile_scoreboard_pkg.sv
// Shared sizing constants and types for the ID-stage register file and
// its pending-write scoreboard.
package id_regfile_scoreboard_pkg;

    localparam int NREGS    = 32;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int MAX_PEND = 3;
    localparam int CW       = 2;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [CW-1:0] pend_t;

    localparam reg_idx_t REG_ZERO  = '0;
    localparam pend_t    PEND_FULL = CW'(MAX_PEND);

endpackage

// File: rtl/id_regfile_scoreboard_if.sv
// Bundle of writeback, read-port, issue and kill signals seen by the ID stage.
// The master side is the pipeline around ID; the slave side is the register
// file / scoreboard block itself.
interface id_regfile_scoreboard_if;
    import id_regfile_scoreboard_pkg::*;

    logic     RegWrite_ID;
    reg_idx_t write_reg_ID;
    data_t    write_data_ID;
    reg_idx_t read_reg1;
    reg_idx_t read_reg2;
    logic     use_rs1;
    logic     use_rs2;
    logic     issue_valid;
    logic     issue_RegWrite;
    reg_idx_t issue_dst;
    logic     kill_valid;
    reg_idx_t kill_dst;
    data_t    read_data1;
    data_t    read_data2;
    logic     stall_ID;
    logic     sb_error;

    modport master (
        output RegWrite_ID, write_reg_ID, write_data_ID,
        output read_reg1, read_reg2, use_rs1, use_rs2,
        output issue_valid, issue_RegWrite, issue_dst,
        output kill_valid, kill_dst,
        input  read_data1, read_data2, stall_ID, sb_error
    );

    modport slave (
        input  RegWrite_ID, write_reg_ID, write_data_ID,
        input  read_reg1, read_reg2, use_rs1, use_rs2,
        input  issue_valid, issue_RegWrite, issue_dst,
        input  kill_valid, kill_dst,
        output read_data1, read_data2, stall_ID, sb_error
    );

endinterface

// File: rtl/id_regfile_scoreboard_regfile_2r1w.sv
// 32-entry register file with one write port and two read ports. A write in
// the current cycle is forwarded straight to any read port addressing the
// same register, so WB results are usable by ID without waiting a cycle.
// Register 0 always reads as zero and is never written.
module regfile_2r1w
    import id_regfile_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     we_i,
    input  reg_idx_t waddr_i,
    input  data_t    wdata_i,
    input  reg_idx_t raddr1_i,
    input  reg_idx_t raddr2_i,
    output data_t    rdata1_o,
    output data_t    rdata2_o
);

    data_t rf_q [NREGS];
    logic  writeEn;

    assign writeEn = we_i && (waddr_i != REG_ZERO);

    // Array update: cleared on reset, otherwise one write per cycle, r0 excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q <= '{default: '0};
        end else if (writeEn) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    // Read muxes: r0 forced to zero, then same-cycle write bypass, then array.
    always_comb begin
        rdata1_o = rf_q[raddr1_i];
        rdata2_o = rf_q[raddr2_i];
        if (raddr1_i == REG_ZERO) begin
            rdata1_o = '0;
        end else if (writeEn && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (raddr2_i == REG_ZERO) begin
            rdata2_o = '0;
        end else if (writeEn && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file plus per-register pending-write counters. Each
// counter tracks how many issued-but-not-yet-written-back producers target
// that register; the stall output holds ID whenever a source is still owed
// a value or a destination counter has no room for another producer.
module id_regfile_scoreboard
    import id_regfile_scoreboard_pkg::*;
(
    input logic clk,
    input logic reset,
    id_regfile_scoreboard_if.slave bus
);

    pend_t pend_q [NREGS];
    pend_t pend_d [NREGS];
    logic  sb_error_q;
    logic  sb_error_d;

    data_t rdata1;
    data_t rdata2;

    logic wbValid;
    logic killValid;
    logic rs1Resolved;
    logic rs2Resolved;
    logic dstDec;
    logic dstFull;
    logic stall;
    logic incValid;
    logic underflow;
    logic signed [CW+1:0] delta;

    regfile_2r1w u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (bus.RegWrite_ID),
        .waddr_i  (bus.write_reg_ID),
        .wdata_i  (bus.write_data_ID),
        .raddr1_i (bus.read_reg1),
        .raddr2_i (bus.read_reg2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    assign wbValid   = bus.RegWrite_ID && (bus.write_reg_ID != REG_ZERO);
    assign killValid = bus.kill_valid && (bus.kill_dst != REG_ZERO);

    // A source is safe when nothing is owed, or the only owed value is arriving
    // on the bypass this very cycle. pend_q[0] is always zero so r0 never stalls.
    always_comb begin
        rs1Resolved = (pend_q[bus.read_reg1] == '0) ||
                      ((pend_q[bus.read_reg1] == CW'(1)) && wbValid &&
                       (bus.write_reg_ID == bus.read_reg1));
        rs2Resolved = (pend_q[bus.read_reg2] == '0) ||
                      ((pend_q[bus.read_reg2] == CW'(1)) && wbValid &&
                       (bus.write_reg_ID == bus.read_reg2));
        dstDec      = (wbValid && (bus.write_reg_ID == bus.issue_dst)) ||
                      (killValid && (bus.kill_dst == bus.issue_dst));
        dstFull     = bus.issue_RegWrite && (bus.issue_dst != REG_ZERO) &&
                      (pend_q[bus.issue_dst] == PEND_FULL) && !dstDec;
        stall       = bus.issue_valid &&
                      ((bus.use_rs1 && !rs1Resolved) ||
                       (bus.use_rs2 && !rs2Resolved) ||
                       dstFull);
        incValid    = bus.issue_valid && bus.issue_RegWrite &&
                      (bus.issue_dst != REG_ZERO) && !stall;
    end

    // Counter next state: every event hitting a register is summed so that
    // coincident issue/writeback/kill combine; a negative result clamps to
    // zero and flags an underflow.
    always_comb begin
        pend_d    = pend_q;
        underflow = 1'b0;
        delta     = '0;
        for (int r = 1; r < NREGS; r++) begin
            delta = {2'b00, pend_q[r]};
            if (incValid && (bus.issue_dst == AW'(r))) begin
                delta = delta + 4'sd1;
            end
            if (wbValid && (bus.write_reg_ID == AW'(r))) begin
                delta = delta - 4'sd1;
            end
            if (killValid && (bus.kill_dst == AW'(r))) begin
                delta = delta - 4'sd1;
            end
            if (delta < 0) begin
                pend_d[r] = '0;
                underflow = 1'b1;
            end else begin
                pend_d[r] = delta[CW-1:0];
            end
        end
        pend_d[0]  = '0;
        sb_error_d = sb_error_q || underflow;
    end

    // Scoreboard state: cleared on reset, otherwise take the summed update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '{default: '0};
            sb_error_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            sb_error_q <= sb_error_d;
        end
    end

    assign bus.read_data1 = rdata1;
    assign bus.read_data2 = rdata2;
    assign bus.stall_ID   = stall;
    assign bus.sb_error   = sb_error_q;

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed bench for the ID register file / scoreboard. Each stimulus cycle
// pushes its hand-computed expected outputs into a queue; a monitor pops one
// entry per cycle at the falling edge and compares it against the DUT.
module tb_id_regfile_scoreboard;
    import id_regfile_scoreboard_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    exp_t expQ[$];
    int   checks;
    int   failures;

    id_regfile_scoreboard_if bus ();

    id_regfile_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic applyStimulus(
        input string name,
        input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic u1, input logic u2,
        input logic iv, input logic irw, input logic [4:0] idst,
        input logic kv, input logic [4:0] kdst,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic es, input logic ee);
        exp_t e;
        bus.RegWrite_ID    = we;
        bus.write_reg_ID   = wreg;
        bus.write_data_ID  = wdata;
        bus.read_reg1      = r1;
        bus.read_reg2      = r2;
        bus.use_rs1        = u1;
        bus.use_rs2        = u2;
        bus.issue_valid    = iv;
        bus.issue_RegWrite = irw;
        bus.issue_dst      = idst;
        bus.kill_valid     = kv;
        bus.kill_dst       = kdst;
        e.name  = name;
        e.rd1   = e1;
        e.rd2   = e2;
        e.stall = es;
        e.err   = ee;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge with whatever inputs are currently applied.
    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare one queued expectation per cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({e.name, ".rd1"},   bus.read_data1, e.rd1);
                checkOutput({e.name, ".rd2"},   bus.read_data2, e.rd2);
                checkOutput({e.name, ".stall"}, {31'd0, bus.stall_ID}, {31'd0, e.stall});
                checkOutput({e.name, ".err"},   {31'd0, bus.sb_error}, {31'd0, e.err});
            end
        end
    end

    // Stimulus sequence.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.RegWrite_ID    = 1'b0;
        bus.write_reg_ID   = '0;
        bus.write_data_ID  = '0;
        bus.read_reg1      = '0;
        bus.read_reg2      = '0;
        bus.use_rs1        = 1'b0;
        bus.use_rs2        = 1'b0;
        bus.issue_valid    = 1'b0;
        bus.issue_RegWrite = 1'b0;
        bus.issue_dst      = '0;
        bus.kill_valid     = 1'b0;
        bus.kill_dst       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset state
        applyStimulus("reset_read",   0, 0, 32'h0,        5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 0, 0);
        // Write r5 with same-cycle bypass, then from the array
        applyStimulus("issue_r5",     0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 5, 0, 0, 32'h0,        32'h0, 0, 0);
        applyStimulus("wb_r5_bypass", 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        applyStimulus("r5_array",     0, 0, 32'h0,        5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0);
        // r0 writes dropped, r0 issue never counted or stalls
        applyStimulus("wb_r0",        1, 0, 32'h1234,     0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0, 0, 0);
        applyStimulus("read_r0",      0, 0, 32'h0,        0, 0, 1, 1, 1, 1, 0, 0, 0, 32'h0,        32'h0, 0, 0);
        // RAW on r7 resolved by same-cycle writeback
        applyStimulus("issue_r7",     0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 7, 0, 0, 32'h0,        32'h0, 0, 0);
        applyStimulus("raw_r7_stall", 0, 0, 32'h0,        7, 5, 1, 0, 1, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 1, 0);
        applyStimulus("raw_r7_wb",    1, 7, 32'hCAFEF00D, 7, 5, 1, 0, 1, 0, 0, 0, 0, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0);
        applyStimulus("r7_resolved",  0, 0, 32'h0,        7, 0, 1, 0, 1, 0, 0, 0, 0, 32'hCAFEF00D, 32'h0, 0, 0);
        // Fill r9 to the in-flight limit
        applyStimulus("issue_r9_1",   0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h0,        32'h0, 0, 0);
        applyStimulus("issue_r9_2",   0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h0,        32'h0, 0, 0);
        applyStimulus("issue_r9_3",   0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h0,        32'h0, 0, 0);
        applyStimulus("r9_full",      0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h0,        32'h0, 1, 0);
        applyStimulus("r9_full_hold", 0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h0,        32'h0, 1, 0);
        applyStimulus("r9_issue_wb",  1, 9, 32'h00000099, 9, 0, 0, 0, 1, 1, 9, 0, 0, 32'h00000099, 32'h0, 0, 0);
        applyStimulus("r9_still_full",0, 0, 32'h0,        9, 0, 0, 0, 1, 1, 9, 0, 0, 32'h00000099, 32'h0, 1, 0);
        applyStimulus("kill_r9",      0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0,        32'h0, 0, 0);
        applyStimulus("r9_refill",    0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 9, 0, 0, 32'h0,        32'h0, 0, 0);
        // Writeback plus kill on the same register removes two
        applyStimulus("r9_wb_kill",   1, 9, 32'hA5A5A5A5, 9, 0, 0, 0, 0, 0, 0, 1, 9, 32'hA5A5A5A5, 32'h0, 0, 0);
        applyStimulus("r9_p1_rs1",    0, 0, 32'h0,        9, 0, 1, 0, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h0, 1, 0);
        applyStimulus("r9_p1_rs2",    0, 0, 32'h0,        0, 9, 0, 1, 1, 0, 0, 0, 0, 32'h0,        32'hA5A5A5A5, 1, 0);
        applyStimulus("kill_r9_last", 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0,        32'h0, 0, 0);
        applyStimulus("r9_clear",     0, 0, 32'h0,        9, 0, 1, 0, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h0, 0, 0);
        // Underflow is sticky until reset; reset clears a live stall
        applyStimulus("kill_r4_uf",   0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h0,        32'h0, 0, 0);
        applyStimulus("err_set",      0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 0, 1);
        applyStimulus("issue_r7_b",   0, 0, 32'h0,        0, 0, 0, 0, 1, 1, 7, 0, 0, 32'h0,        32'h0, 0, 1);
        applyStimulus("r7_pre_reset", 0, 0, 32'h0,        7, 5, 1, 0, 1, 0, 0, 0, 0, 32'hCAFEF00D, 32'hDEADBEEF, 1, 1);
        doReset();
        applyStimulus("after_reset",  0, 0, 32'h0,        7, 5, 1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0, 0, 0);

        // Give the monitor a bounded window to drain any outstanding entries.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
